sctrl_ring: RTL and testbench

- Synchronous, parametrised successor to the WCHB control ring. Circulates tokens through NSTAGE stages and emits one-cycle stage-enable pulses.
- Emulates the asynchronous request/acknowledge timing: each ring edge has a run-time programmable hop delay, each stage has a stall, and the whole ring has a global run gate.
- Drives the stage registers of the clocked RISC-V datapath in place of the self-timed aclk bundle. Used for FPGA prototyping and for delay/occupancy exploration.

---
 rtl/sctrl_ring_pkg.sv | 23 ++
 rtl/sctrl_ring_stage.sv | 69 ++++++
 rtl/sctrl_ring.sv | 88 ++++++++
 tb/tb_sctrl_ring.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sctrl_ring_pkg.sv
// Shared types and helpers for the synchronous control ring: stage state
// encoding, the stage-count ceiling and a popcount used for occupancy.
package sctrl_pkg;

    localparam int NSTAGE_MAX = 32;
    localparam int OCC_MAX_W  = $clog2(NSTAGE_MAX + 1);

    typedef enum logic [1:0] {
        EMPTY,
        WAIT,
        READY
    } stage_state_e;

    function automatic logic [OCC_MAX_W-1:0] popcount(input logic [NSTAGE_MAX-1:0] v);
        logic [OCC_MAX_W-1:0] n;
        n = '0;
        for (int i = 0; i < NSTAGE_MAX; i++) begin
            n = n + OCC_MAX_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/sctrl_ring_stage.sv
// One ring stage: token-present state, hop-delay down-counter, ready decode
// and the one-cycle capture pulse that stands in for the stage's aclk.
module sctrl_stage
    import sctrl_pkg::*;
#(
    parameter int DLY_W     = 4,
    parameter bit INIT_FULL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             stall,
    input  logic [DLY_W-1:0] delay,
    input  logic             prev_ready,
    input  logic             next_full,
    output logic             full,
    output logic             ready,
    output logic             fire
);

    stage_state_e     state;
    logic [DLY_W-1:0] cnt;
    logic             take;
    logic             give;

    assign full  = (state != EMPTY);
    assign ready = (state == READY) && !stall && run;

    // Both handshake terms look only at registered state, so a stage never
    // vacates and refills in one cycle and no combinational loop closes.
    assign take  = prev_ready && (state == EMPTY);
    assign give  = ready && !next_full;

    // NOTE: every register here uses <= so all stages see the pre-edge
    // state of their neighbours; a blocking assignment would let one stage's
    // update leak into the next stage's decision within the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT_FULL ? READY : EMPTY;
            cnt   <= '0;
            fire  <= 1'b0;
        end else begin
            fire <= 1'b0;
            case (state)
                EMPTY: begin
                    if (take) begin
                        cnt   <= delay;
                        state <= (delay == '0) ? READY : WAIT;
                        fire  <= 1'b1;
                    end
                end
                WAIT: begin
                    // Counting ignores run and stall; only the departure is gated.
                    cnt <= cnt - 1'b1;
                    if (cnt == DLY_W'(1)) begin
                        state <= READY;
                    end
                end
                READY: begin
                    if (give) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/sctrl_ring.sv
// Synchronous token ring replacing the self-timed WCHB control ring.
// Optional idle watchdog enabled with `define SCTRL_RING_DEADLOCK_DET_EN.
module sctrl_ring
    import sctrl_pkg::*;
#(
    parameter int                NSTAGE    = 6,
    parameter int                DLY_W     = 4,
    parameter logic [NSTAGE-1:0] INIT_MASK = NSTAGE'(1)
`ifdef SCTRL_RING_DEADLOCK_DET_EN
    ,
    parameter int                DL_TIMEOUT = 256
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_run,
    input  logic [NSTAGE-1:0]             i_stall,
    input  logic [NSTAGE*DLY_W-1:0]       i_delay,
    output logic [NSTAGE-1:0]             o_fire,
    output logic [NSTAGE-1:0]             o_full,
    output logic [$clog2(NSTAGE+1)-1:0]   o_occupancy
`ifdef SCTRL_RING_DEADLOCK_DET_EN
    ,
    output logic                          o_deadlock
`endif
);

    localparam int OCC_W = $clog2(NSTAGE + 1);

    if (NSTAGE < 2 || NSTAGE > NSTAGE_MAX) begin : g_bad_nstage
        $fatal(1, "sctrl_ring: NSTAGE=%0d outside 2..%0d", NSTAGE, NSTAGE_MAX);
    end

    logic [NSTAGE-1:0] full;
    logic [NSTAGE-1:0] ready;
    logic [NSTAGE-1:0] fire;

    for (genvar i = 0; i < NSTAGE; i++) begin : g_stage
        localparam int PREV = (i == 0) ? NSTAGE - 1 : i - 1;
        localparam int NEXT = (i == NSTAGE - 1) ? 0 : i + 1;

        sctrl_stage #(
            .DLY_W     (DLY_W),
            .INIT_FULL (INIT_MASK[i])
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .run        (i_run),
            .stall      (i_stall[i]),
            .delay      (i_delay[i*DLY_W +: DLY_W]),
            .prev_ready (ready[PREV]),
            .next_full  (full[NEXT]),
            .full       (full[i]),
            .ready      (ready[i]),
            .fire       (fire[i])
        );
    end

    assign o_fire      = fire;
    assign o_full      = full;
    // Decoded from the registered full bits, so it equals popcount(INIT_MASK)
    // straight out of reset and stays there while tokens circulate.
    assign o_occupancy = OCC_W'(popcount(NSTAGE_MAX'(full)));

`ifdef SCTRL_RING_DEADLOCK_DET_EN
    localparam int IDLE_W = $clog2(DL_TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_cnt;
    logic [IDLE_W-1:0] idle_nxt;

    assign idle_nxt = idle_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt   <= '0;
            o_deadlock <= 1'b0;
        end else if (|fire || !i_run) begin
            idle_cnt <= '0;
        end else if (!o_deadlock) begin
            idle_cnt <= idle_nxt;
            if (idle_nxt == IDLE_W'(DL_TIMEOUT)) begin
                o_deadlock <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sctrl_ring.sv
// Self-checking bench for sctrl_ring: single token, two tokens and a full
// (deadlocked) ring run side by side from shared stimulus.
module tb_sctrl_ring;

    localparam int N  = 6;
    localparam int DW = 4;
    localparam int OW = $clog2(N + 1);
    localparam logic [N-1:0] MASKS [3] = '{6'b000001, 6'b000011, 6'b111111};

    logic              clk = 1'b0;
    logic              rst;
    logic              run;
    logic [N-1:0]      stall;
    logic [N*DW-1:0]   delay;
    logic [N-1:0]      fire [3];
    logic [N-1:0]      full [3];
    logic [OW-1:0]     occ  [3];
`ifdef SCTRL_RING_DEADLOCK_DET_EN
    logic              dl   [3];
`endif

    int            total = 0;
    int            bad   = 0;
    logic [N-1:0]  exp_q [$];
    int            d_cfg [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
`ifdef SCTRL_RING_DEADLOCK_DET_EN
        sctrl_ring #(.NSTAGE(N), .DLY_W(DW), .INIT_MASK(MASKS[g]), .DL_TIMEOUT(16)) u_dut (
            .clk(clk), .rst(rst), .i_run(run), .i_stall(stall), .i_delay(delay),
            .o_fire(fire[g]), .o_full(full[g]), .o_occupancy(occ[g]), .o_deadlock(dl[g])
        );
`else
        sctrl_ring #(.NSTAGE(N), .DLY_W(DW), .INIT_MASK(MASKS[g])) u_dut (
            .clk(clk), .rst(rst), .i_run(run), .i_stall(stall), .i_delay(delay),
            .o_fire(fire[g]), .o_full(full[g]), .o_occupancy(occ[g])
        );
`endif
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic apply_delays();
        for (int i = 0; i < N; i++) delay[i*DW +: DW] = DW'(d_cfg[i]);
    endtask

    // Expected o_fire per cycle for a lone token released from stage 0 at
    // reset: it enters stage p at cycle c and leaves at c+1+d[p].
    task automatic push_single(input int ncyc);
        int pos;
        int leave;
        pos   = 0;
        leave = 1;
        for (int c = 1; c <= ncyc; c++) begin
            if (c == leave) begin
                pos   = (pos + 1) % N;
                leave = c + 1 + d_cfg[pos];
                exp_q.push_back(N'(1) << pos);
            end else begin
                exp_q.push_back('0);
            end
        end
    endtask

    task automatic test_reset();
        run = 1'b1; stall = '0;
        for (int i = 0; i < N; i++) d_cfg[i] = 0;
        apply_delays();
        do_reset();
        for (int g = 0; g < 3; g++) begin
            total++;
            if (full[g] !== MASKS[g]) begin
                bad++; $display("FAIL reset_full dut=%0d got=%b want=%b", g, full[g], MASKS[g]);
            end
            total++;
            if (fire[g] !== '0) begin
                bad++; $display("FAIL reset_fire dut=%0d got=%b want=0", g, fire[g]);
            end
        end
        total++;
        if (occ[0] !== OW'(1) || occ[1] !== OW'(2) || occ[2] !== OW'(6)) begin
            bad++; $display("FAIL reset_occ got=%0d/%0d/%0d want=1/2/6", occ[0], occ[1], occ[2]);
        end
    endtask

    task automatic test_walk();
        logic [N-1:0] e;
        for (int i = 0; i < N; i++) d_cfg[i] = 0;
        apply_delays();
        do_reset();
        push_single(13);
        for (int c = 1; exp_q.size() > 0; c++) begin
            tick();
            e = exp_q.pop_front();
            total++;
            if (fire[0] !== e) begin
                bad++; $display("FAIL walk_fire cyc=%0d got=%b want=%b", c, fire[0], e);
            end
            total++;
            if (occ[0] !== OW'(1)) begin
                bad++; $display("FAIL walk_occ cyc=%0d got=%0d want=1", c, occ[0]);
            end
        end
    endtask

    task automatic test_delay();
        logic [N-1:0] e;
        int t2, t3, f1a, f1b;
        t2 = -1; t3 = -1; f1a = -1; f1b = -1;
        for (int i = 0; i < N; i++) d_cfg[i] = 0;
        d_cfg[2] = 3;
        apply_delays();
        do_reset();
        push_single(20);
        for (int c = 1; exp_q.size() > 0; c++) begin
            tick();
            e = exp_q.pop_front();
            total++;
            if (fire[0] !== e) begin
                bad++; $display("FAIL delay_fire cyc=%0d got=%b want=%b", c, fire[0], e);
            end
            if (fire[0][2] === 1'b1 && t2 < 0) t2 = c;
            if (fire[0][3] === 1'b1 && t3 < 0) t3 = c;
            if (fire[0][1] === 1'b1) begin
                if (f1a < 0) f1a = c;
                else if (f1b < 0) f1b = c;
            end
        end
        total++;
        if (t3 - t2 !== 4) begin
            bad++; $display("FAIL delay_gap got=%0d want=4", t3 - t2);
        end
        total++;
        if (f1b - f1a !== 9) begin
            bad++; $display("FAIL delay_period got=%0d want=9", f1b - f1a);
        end
    endtask

    task automatic test_two_token();
        logic [N-1:0] e;
        logic [N-1:0] cyc_tbl [6];
        cyc_tbl = '{6'b001010, 6'b010100, 6'b101000, 6'b010001, 6'b100010, 6'b000101};
        for (int i = 0; i < N; i++) d_cfg[i] = 0;
        apply_delays();
        do_reset();
        exp_q.push_back(6'b000100);
        for (int c = 0; c < 12; c++) exp_q.push_back(cyc_tbl[c % 6]);
        for (int c = 1; exp_q.size() > 0; c++) begin
            tick();
            e = exp_q.pop_front();
            total++;
            if (fire[1] !== e) begin
                bad++; $display("FAIL two_fire cyc=%0d got=%b want=%b", c, fire[1], e);
            end
            total++;
            if ((fire[1] & {fire[1][0], fire[1][N-1:1]}) !== '0) begin
                bad++; $display("FAIL two_adjacent cyc=%0d got=%b want=no adjacent pair", c, fire[1]);
            end
            total++;
            if (occ[1] !== OW'(2)) begin
                bad++; $display("FAIL two_occ cyc=%0d got=%0d want=2", c, occ[1]);
            end
        end
    endtask

    task automatic test_stall();
        logic [N-1:0] e;
        for (int i = 0; i < N; i++) d_cfg[i] = 0;
        apply_delays();
        do_reset();
        push_single(3);
        for (int c = 0; c < 10; c++) exp_q.push_back('0);
        for (int c = 1; exp_q.size() > 0; c++) begin
            tick();
            e = exp_q.pop_front();
            total++;
            if (fire[0] !== e) begin
                bad++; $display("FAIL stall_fire cyc=%0d got=%b want=%b", c, fire[0], e);
            end
            if (c == 3) stall[3] = 1'b1;
        end
        total++;
        if (full[0] !== 6'b001000) begin
            bad++; $display("FAIL stall_full got=%b want=001000", full[0]);
        end
        stall[3] = 1'b0;
        tick();
        total++;
        if (fire[0] !== 6'b010000) begin
            bad++; $display("FAIL stall_release got=%b want=010000", fire[0]);
        end
    endtask

    task automatic test_run_gate();
        logic [N-1:0] e;
        for (int i = 0; i < N; i++) d_cfg[i] = 0;
        d_cfg[2] = 3;
        apply_delays();
        do_reset();
        push_single(2);
        for (int c = 0; c < 6; c++) exp_q.push_back('0);
        exp_q.push_back(6'b001000);
        for (int c = 1; exp_q.size() > 0; c++) begin
            tick();
            e = exp_q.pop_front();
            total++;
            if (fire[0] !== e) begin
                bad++; $display("FAIL run_fire cyc=%0d got=%b want=%b", c, fire[0], e);
            end
            if (c == 2) run = 1'b0;
            if (c == 8) begin
                total++;
                if (full[0] !== 6'b000100) begin
                    bad++; $display("FAIL run_hold_full got=%b want=000100", full[0]);
                end
                run = 1'b1;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] e;
        for (int i = 0; i < N; i++) d_cfg[i] = 0;
        d_cfg[2] = 3;
        apply_delays();
        do_reset();
        push_single(3);
        for (int c = 1; exp_q.size() > 0; c++) begin
            tick();
            e = exp_q.pop_front();
            total++;
            if (fire[0] !== e) begin
                bad++; $display("FAIL rmid_pre cyc=%0d got=%b want=%b", c, fire[0], e);
            end
        end
        do_reset();
        total++;
        if (full[0] !== 6'b000001 || fire[0] !== '0 || occ[0] !== OW'(1)) begin
            bad++; $display("FAIL rmid_state full=%b fire=%b occ=%0d want 000001/0/1", full[0], fire[0], occ[0]);
        end
        tick();
        total++;
        if (fire[0] !== 6'b000010) begin
            bad++; $display("FAIL rmid_restart got=%b want=000010", fire[0]);
        end
    endtask

    task automatic test_deadlock();
        for (int i = 0; i < N; i++) d_cfg[i] = 0;
        apply_delays();
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            tick();
            total++;
            if (fire[2] !== '0 || full[2] !== 6'b111111 || occ[2] !== OW'(6)) begin
                bad++; $display("FAIL full_ring cyc=%0d fire=%b full=%b occ=%0d", c, fire[2], full[2], occ[2]);
            end
`ifdef SCTRL_RING_DEADLOCK_DET_EN
            total++;
            if (dl[2] !== (c >= 16)) begin
                bad++; $display("FAIL dl_flag cyc=%0d got=%b want=%b", c, dl[2], c >= 16);
            end
            total++;
            if (dl[0] !== 1'b0) begin
                bad++; $display("FAIL dl_live cyc=%0d got=%b want=0", c, dl[0]);
            end
`endif
        end
    endtask

    initial begin
        rst = 1'b1; run = 1'b1; stall = '0; delay = '0;
        test_reset();
        test_walk();
        test_delay();
        test_two_token();
        test_stall();
        test_run_gate();
        test_reset_mid();
        test_deadlock();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
